qpu_dtcm_icb_arbiter: RTL and testbench

Two-requester ICB arbiter that shares the single LSU/DTCM command port between the EXU (requester 0) and an external host/MCU loader (requester 1). It sits between the EXU's `lsu_icb_cmd_*` outputs and the LSU top. Commands are granted round-robin, and a grant is held stable while the downstream port stalls. Responses return to the issuing requester through an in-order outstanding-ID FIFO.

---
 rtl/qpu_dtcm_icb_arbiter_pkg.sv | 15 +
 rtl/qpu_arb_id_fifo.sv | 59 +++++
 rtl/qpu_dtcm_icb_arbiter.sv | 135 +++++++++++++
 tb/tb_qpu_dtcm_icb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_dtcm_icb_arbiter_pkg.sv
// Shared types for the DTCM ICB arbiter: requester count, arbiter state
// encoding and the outstanding-ID type.
package qpu_dtcm_icb_arbiter_pkg;

    localparam int QPU_ARB_REQ_NUM = 2;
    localparam int QPU_ARB_ID_W    = 1;

    typedef logic [QPU_ARB_ID_W-1:0] arb_id_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/qpu_arb_id_fifo.sv
// In-order FIFO of requester IDs for commands still awaiting a response.
// A push is accepted while full only if a pop happens in the same cycle.
module qpu_arb_id_fifo
    import qpu_dtcm_icb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  arb_id_t wdata,
    output arb_id_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_id_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (DEPTH == 1) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/qpu_dtcm_icb_arbiter.sv
// Round-robin arbiter sharing the LSU/DTCM ICB port between the EXU (r0) and
// the host loader (r1); responses are routed back via an outstanding-ID FIFO.
//   state | meaning
//   IDLE  | free round-robin choice between valid requesters
//   HOLD  | downstream stalled, grant pinned to hold_id until handshake
module qpu_dtcm_icb_arbiter
    import qpu_dtcm_icb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r0_cmd_valid,
    output logic                r0_cmd_ready,
    input  logic [ADDR_W-1:0]   r0_cmd_addr,
    input  logic                r0_cmd_read,
    input  logic [DATA_W-1:0]   r0_cmd_wdata,
    input  logic [DATA_W/8-1:0] r0_cmd_wmask,
    output logic                r0_rsp_valid,
    input  logic                r0_rsp_ready,
    output logic [DATA_W-1:0]   r0_rsp_rdata,
    input  logic                r1_cmd_valid,
    output logic                r1_cmd_ready,
    input  logic [ADDR_W-1:0]   r1_cmd_addr,
    input  logic                r1_cmd_read,
    input  logic [DATA_W-1:0]   r1_cmd_wdata,
    input  logic [DATA_W/8-1:0] r1_cmd_wmask,
    output logic                r1_rsp_valid,
    input  logic                r1_rsp_ready,
    output logic [DATA_W-1:0]   r1_rsp_rdata,
    output logic                m_cmd_valid,
    input  logic                m_cmd_ready,
    output logic [ADDR_W-1:0]   m_cmd_addr,
    output logic                m_cmd_read,
    output logic [DATA_W-1:0]   m_cmd_wdata,
    output logic [DATA_W/8-1:0] m_cmd_wmask,
    input  logic                m_rsp_valid,
    output logic                m_rsp_ready,
    input  logic [DATA_W-1:0]   m_rsp_rdata,
    output logic                orphan_err,
    output logic                arb_active
);

    arb_state_e state_q, state_d;
    arb_id_t    rr_last_q, rr_last_d;
    arb_id_t    hold_id_q, hold_id_d;
    logic       orphan_q, orphan_d;

    arb_id_t    winner, head_id;
    logic       winner_valid, cmd_block, cmd_hs;
    logic       fifo_full, fifo_empty, rsp_pop;

    qpu_arb_id_fifo #(.DEPTH(OUTS_DEPTH)) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs),
        .pop   (rsp_pop),
        .wdata (winner),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            rr_last_q <= 1'b1;
            hold_id_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            hold_id_q <= hold_id_d;
            orphan_q  <= orphan_d;
        end
    end

    // Winner depends only on requester valids and state, never on m_cmd_ready.
    always_comb begin
        winner       = 1'b0;
        winner_valid = 1'b0;
        if (state_q == ARB_HOLD) begin
            winner       = hold_id_q;
            winner_valid = hold_id_q ? r1_cmd_valid : r0_cmd_valid;
        end else if (r0_cmd_valid && r1_cmd_valid) begin
            winner       = ~rr_last_q;
            winner_valid = 1'b1;
        end else if (r1_cmd_valid) begin
            winner       = 1'b1;
            winner_valid = 1'b1;
        end else if (r0_cmd_valid) begin
            winner_valid = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        hold_id_d = hold_id_q;
        orphan_d  = orphan_q | (m_rsp_valid & fifo_empty);
        if (cmd_hs) begin
            rr_last_d = winner;
            state_d   = ARB_IDLE;
        end else if (state_q == ARB_IDLE && winner_valid) begin
            hold_id_d = winner;
            state_d   = ARB_HOLD;
        end else if (state_q == ARB_HOLD && !winner_valid) begin
            state_d   = ARB_IDLE;
        end
    end

    // A full FIFO still admits a command when a response retires in the same cycle.
    always_comb begin
        rsp_pop      = m_rsp_valid & m_rsp_ready & ~fifo_empty;
        cmd_block    = fifo_full & ~rsp_pop;
        m_cmd_valid  = winner_valid & ~cmd_block;
        cmd_hs       = m_cmd_valid & m_cmd_ready;
        r0_cmd_ready = m_cmd_ready & ~cmd_block & (winner == 1'b0);
        r1_cmd_ready = m_cmd_ready & ~cmd_block & (winner == 1'b1);
        m_cmd_addr   = winner ? r1_cmd_addr  : r0_cmd_addr;
        m_cmd_read   = winner ? r1_cmd_read  : r0_cmd_read;
        m_cmd_wdata  = winner ? r1_cmd_wdata : r0_cmd_wdata;
        m_cmd_wmask  = winner ? r1_cmd_wmask : r0_cmd_wmask;
        r0_rsp_valid = m_rsp_valid & ~fifo_empty & (head_id == 1'b0);
        r1_rsp_valid = m_rsp_valid & ~fifo_empty & (head_id == 1'b1);
        m_rsp_ready  = fifo_empty ? m_rsp_valid : (head_id ? r1_rsp_ready : r0_rsp_ready);
        r0_rsp_rdata = m_rsp_rdata;
        r1_rsp_rdata = m_rsp_rdata;
        orphan_err   = orphan_q;
        arb_active   = r0_cmd_valid | r1_cmd_valid | ~fifo_empty | (state_q == ARB_HOLD);
    end

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// Directed bench for qpu_dtcm_icb_arbiter with hand-computed expectations.
module tb_qpu_dtcm_icb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_cmd_valid, r0_cmd_ready, r0_cmd_read, r0_rsp_valid, r0_rsp_ready;
    logic        r1_cmd_valid, r1_cmd_ready, r1_cmd_read, r1_rsp_valid, r1_rsp_ready;
    logic [15:0] r0_cmd_addr, r1_cmd_addr, m_cmd_addr;
    logic [31:0] r0_cmd_wdata, r1_cmd_wdata, m_cmd_wdata;
    logic [3:0]  r0_cmd_wmask, r1_cmd_wmask, m_cmd_wmask;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata, m_rsp_rdata;
    logic        m_cmd_valid, m_cmd_ready, m_cmd_read;
    logic        m_rsp_valid, m_rsp_ready;
    logic        orphan_err, arb_active;

    int n_chk = 0;
    int n_err = 0;

    qpu_dtcm_icb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_cmd_valid(r0_cmd_valid), .r0_cmd_ready(r0_cmd_ready), .r0_cmd_addr(r0_cmd_addr),
        .r0_cmd_read(r0_cmd_read), .r0_cmd_wdata(r0_cmd_wdata), .r0_cmd_wmask(r0_cmd_wmask),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_cmd_valid(r1_cmd_valid), .r1_cmd_ready(r1_cmd_ready), .r1_cmd_addr(r1_cmd_addr),
        .r1_cmd_read(r1_cmd_read), .r1_cmd_wdata(r1_cmd_wdata), .r1_cmd_wmask(r1_cmd_wmask),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_rdata(r1_rsp_rdata),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
        .orphan_err(orphan_err), .arb_active(arb_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r0_cmd_valid = 0; r0_cmd_addr = 16'h0100; r0_cmd_read = 1; r0_cmd_wdata = 32'h1111_0000;
        r0_cmd_wmask = 4'hF; r0_rsp_ready = 1;
        r1_cmd_valid = 0; r1_cmd_addr = 16'h0200; r1_cmd_read = 0; r1_cmd_wdata = 32'h2222_0000;
        r1_cmd_wmask = 4'h3; r1_rsp_ready = 1;
        m_cmd_ready = 0; m_rsp_valid = 0; m_rsp_rdata = 32'h0;
        r0_rsp_ready = 0; r1_rsp_ready = 0;
        step(); step();

        // reset state with inputs low
        settle();
        chk("rst_m_cmd_valid", m_cmd_valid, 0);
        chk("rst_r0_cmd_ready", r0_cmd_ready, 0);
        chk("rst_r1_cmd_ready", r1_cmd_ready, 0);
        chk("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
        chk("rst_m_rsp_ready", m_rsp_ready, 0);
        chk("rst_arb_active", arb_active, 0);
        chk("rst_orphan", orphan_err, 0);
        rst_n = 1'b1;
        step();

        // tie-break: grants 0,1,0,1 with responses overlapping while the FIFO is full
        r0_cmd_valid = 1; r1_cmd_valid = 1; m_cmd_ready = 1;
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        settle();
        chk("tie1_addr", m_cmd_addr, 16'h0100);
        chk("tie1_r0_ready", r0_cmd_ready, 1);
        chk("tie1_r1_ready", r1_cmd_ready, 0);
        chk("tie1_wmask", m_cmd_wmask, 4'hF);
        step();
        settle();
        chk("tie2_addr", m_cmd_addr, 16'h0200);
        chk("tie2_r1_ready", r1_cmd_ready, 1);
        chk("tie2_read", m_cmd_read, 0);
        chk("tie2_wdata", m_cmd_wdata, 32'h2222_0000);
        step();
        m_rsp_valid = 1; m_rsp_rdata = 32'hA0;
        settle();
        chk("tie3_m_cmd_valid", m_cmd_valid, 1);
        chk("tie3_addr", m_cmd_addr, 16'h0100);
        chk("tie3_r0_rsp_valid", r0_rsp_valid, 1);
        chk("tie3_r1_rsp_valid", r1_rsp_valid, 0);
        chk("tie3_r0_rdata", r0_rsp_rdata, 32'hA0);
        step();
        m_rsp_rdata = 32'hA1;
        settle();
        chk("tie4_addr", m_cmd_addr, 16'h0200);
        chk("tie4_r1_rsp_valid", r1_rsp_valid, 1);
        chk("tie4_r0_rsp_valid", r0_rsp_valid, 0);
        chk("tie4_r1_rdata", r1_rsp_rdata, 32'hA1);
        step();
        r0_cmd_valid = 0; r1_cmd_valid = 0; m_rsp_rdata = 32'hA2;
        settle();
        chk("tie5_r0_rsp_valid", r0_rsp_valid, 1);
        chk("tie5_r0_rdata", r0_rsp_rdata, 32'hA2);
        step();
        m_rsp_rdata = 32'hA3;
        settle();
        chk("tie6_r1_rsp_valid", r1_rsp_valid, 1);
        chk("tie6_r1_rdata", r1_rsp_rdata, 32'hA3);
        step();
        m_rsp_valid = 0;
        settle();
        chk("tie_drained_active", arb_active, 0);
        chk("tie_no_orphan", orphan_err, 0);

        // FIFO full: two reads fill it, third blocked, push+pop keeps it full
        r0_cmd_valid = 1;
        step(); step();
        settle();
        chk("full_m_cmd_valid", m_cmd_valid, 0);
        chk("full_r0_ready", r0_cmd_ready, 0);
        step();
        m_rsp_valid = 1; m_rsp_rdata = 32'hB0;
        settle();
        chk("full_pp_m_cmd_valid", m_cmd_valid, 1);
        chk("full_pp_r0_ready", r0_cmd_ready, 1);
        chk("full_pp_rsp_valid", r0_rsp_valid, 1);
        step();
        m_rsp_valid = 0;
        settle();
        chk("full_still_full", m_cmd_valid, 0);
        step();
        r0_cmd_valid = 0; m_rsp_valid = 1;
        step(); step();
        m_rsp_valid = 0;
        settle();
        chk("full_drained_active", arb_active, 0);
        chk("full_no_orphan", orphan_err, 0);

        // stall hold: last winner is r0, so r1 would win a free tie
        r0_cmd_valid = 1; r0_cmd_addr = 16'h0010; m_cmd_ready = 0;
        settle();
        chk("stall0_addr", m_cmd_addr, 16'h0010);
        chk("stall0_valid", m_cmd_valid, 1);
        step();
        r1_cmd_valid = 1; r1_cmd_addr = 16'h0020;
        settle();
        chk("stall1_addr", m_cmd_addr, 16'h0010);
        step();
        settle();
        chk("stall2_addr", m_cmd_addr, 16'h0010);
        chk("stall2_active", arb_active, 1);
        step();
        m_cmd_ready = 1;
        settle();
        chk("stall_hs_addr", m_cmd_addr, 16'h0010);
        chk("stall_hs_r0_ready", r0_cmd_ready, 1);
        chk("stall_hs_r1_ready", r1_cmd_ready, 0);
        step();
        r0_cmd_valid = 0;
        settle();
        chk("stall_next_addr", m_cmd_addr, 16'h0020);
        chk("stall_next_r1_ready", r1_cmd_ready, 1);
        step();
        r1_cmd_valid = 0; m_cmd_ready = 0;

        // response backpressure: r0 entry pops, r1 entry stalls
        m_rsp_valid = 1; m_rsp_rdata = 32'h55;
        settle();
        chk("bp_r0_rsp_valid", r0_rsp_valid, 1);
        step();
        r1_rsp_ready = 0;
        settle();
        chk("bp_m_rsp_ready", m_rsp_ready, 0);
        chk("bp_r0_rsp_valid0", r0_rsp_valid, 0);
        chk("bp_r1_rsp_valid", r1_rsp_valid, 1);
        step();
        settle();
        chk("bp_not_popped", r1_rsp_valid, 1);
        chk("bp_m_rsp_ready2", m_rsp_ready, 0);
        r1_rsp_ready = 1;
        settle();
        chk("bp_release", m_rsp_ready, 1);
        step();
        m_rsp_valid = 0;
        settle();
        chk("bp_drained_active", arb_active, 0);
        chk("bp_no_orphan", orphan_err, 0);

        // orphan response
        m_rsp_valid = 1; m_rsp_rdata = 32'hDEAD;
        settle();
        chk("orph_m_rsp_ready", m_rsp_ready, 1);
        chk("orph_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
        chk("orph_same_cycle", orphan_err, 0);
        step();
        m_rsp_valid = 0;
        settle();
        chk("orph_set", orphan_err, 1);
        step(); step();
        chk("orph_sticky", orphan_err, 1);

        // mid-transaction reset: one outstanding r0 command, rr_last becomes 0
        r0_cmd_valid = 1; r0_cmd_addr = 16'h0100; m_cmd_ready = 1;
        step();
        r0_cmd_valid = 0; m_cmd_ready = 0;
        settle();
        chk("mrst_active_before", arb_active, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        settle();
        chk("mrst_active_after", arb_active, 0);
        chk("mrst_orphan_cleared", orphan_err, 0);
        r0_cmd_valid = 1; r1_cmd_valid = 1; m_cmd_ready = 1;
        settle();
        chk("mrst_tie_addr", m_cmd_addr, 16'h0100);
        chk("mrst_tie_r0_ready", r0_cmd_ready, 1);
        step();
        r0_cmd_valid = 0; r1_cmd_valid = 0; m_cmd_ready = 0;
        m_rsp_valid = 1; m_rsp_rdata = 32'h77;
        settle();
        chk("mrst_rsp_r0", r0_rsp_valid, 1);
        step();
        m_rsp_valid = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
